// File: rtl/exp_accel_pkg.sv
// Shared definitions for the exponent accelerator.
// Holds the register word addresses, the STATUS bit positions and the
// engine state encoding. Both the Avalon front end and the engine import it.
package exp_accel_pkg;

    typedef enum logic [2:0] {
        ADDR_BASE   = 3'd0,
        ADDR_EXP    = 3'd1,
        ADDR_CTRL   = 3'd2,
        ADDR_STATUS = 3'd3,
        ADDR_RESULT = 3'd4
    } reg_addr_e;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } eng_state_e;

endpackage

// File: rtl/exp_accel_engine.sv
// Iterative square-and-multiply engine: result = base^exp, truncated to WIDTH.
// One exponent bit is consumed per RUN cycle, LSB first.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle start request (ignored while running)
//   base, exp   - operands, snapshotted on an accepted start
//   busy        - computation in progress
//   done        - result valid; held until next accepted start or reset
//   overflow    - the true power did not fit in WIDTH bits
//   result      - truncated power
module exp_accel_engine
    import exp_accel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [WIDTH-1:0] result
);

    eng_state_e state_q, state_d;

    logic [WIDTH-1:0]   acc_q, b_q, e_q;
    logic               b_ovf_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   result_q;

    logic [2*WIDTH-1:0] prod_ab, prod_bb;
    logic [WIDTH-1:0]   e_shift;
    logic [WIDTH-1:0]   acc_next;
    logic               accept;

    assign prod_ab  = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b_q};
    assign prod_bb  = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, b_q};
    assign e_shift  = e_q >> 1;
    assign acc_next = e_q[0] ? prod_ab[WIDTH-1:0] : acc_q;
    // Starts are honoured from IDLE and DONE only; a start during RUN is dropped.
    assign accept   = start && (state_q != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (exp == '0) ? DONE : RUN;
            RUN:        if (e_shift == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            b_q      <= '0;
            e_q      <= '0;
            b_ovf_q  <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            acc_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
            b_q     <= base;
            e_q     <= exp;
            b_ovf_q <= 1'b0;
            ovf_q   <= 1'b0;
            if (exp == '0) result_q <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (state_q == RUN) begin
            if (e_q[0]) begin
                acc_q <= prod_ab[WIDTH-1:0];
                // A truncated b only matters if it multiplies a non-zero acc;
                // the old acc is the one that meets the bad b.
                if (prod_ab[2*WIDTH-1:WIDTH] != '0 || (b_ovf_q && acc_q != '0))
                    ovf_q <= 1'b1;
            end
            b_q <= prod_bb[WIDTH-1:0];
            if (prod_bb[2*WIDTH-1:WIDTH] != '0) b_ovf_q <= 1'b1;
            e_q <= e_shift;
            if (e_shift == '0) result_q <= acc_next;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;
    assign result   = result_q;

endmodule

// File: rtl/exp_accel_core.sv
// Avalon-MM slave wrapper around the power engine.
// Word map: 0 BASE (rw), 1 EXP (rw), 2 CTRL (wo, bit0 = start),
//           3 STATUS (ro: busy/done/overflow), 4 RESULT (ro), 5-7 read 0.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   avs_address    - word address
//   avs_read       - read strobe, data returned next cycle
//   avs_write      - write strobe
//   avs_writedata  - write data
//   avs_readdata   - registered read data, held between reads
module exp_accel_core
    import exp_accel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [WIDTH-1:0] avs_writedata,
    output logic [WIDTH-1:0] avs_readdata
);

    logic [WIDTH-1:0] base_q, exp_q;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] result;
    logic             busy, done, overflow;
    logic             start;

    assign start = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0];

    // Operand registers stay writable while the engine runs; the engine
    // works from its own snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            exp_q  <= '0;
        end else if (avs_write) begin
            if (avs_address == ADDR_BASE) base_q <= avs_writedata;
            if (avs_address == ADDR_EXP)  exp_q  <= avs_writedata;
        end
    end

    exp_accel_engine #(.WIDTH(WIDTH)) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base_q),
        .exp      (exp_q),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .result   (result)
    );

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_BASE:   rd_mux = base_q;
            ADDR_EXP:    rd_mux = exp_q;
            ADDR_STATUS: begin
                rd_mux[ST_BUSY] = busy;
                rd_mux[ST_DONE] = done;
                rd_mux[ST_OVF]  = overflow;
            end
            ADDR_RESULT: rd_mux = result;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_mux;
    end

endmodule

// File: tb/tb_exp_accel_core.sv
// Bench for exp_accel_core: register-level stimulus with a scoreboard queue.
// Reads push their expected value; a monitor compares on the return cycle.
module tb_exp_accel_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;

    always #5 clk = ~clk;

    exp_accel_core #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [31:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_zero = 1'b0;   // monitor: readdata must be 0 this cycle
    bit   chk_drain = 1'b0;  // monitor: scoreboard must be empty
    logic rd_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= avs_read;
    end

    // Monitor: the only process that steps the counters.
    always @(negedge clk) begin
        exp_t e;
        if (rd_pend) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: got %h, none expected", avs_readdata);
            end else begin
                e = sb_q.pop_front();
                if ((avs_readdata & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h (mask %h)",
                             e.name, avs_readdata, e.val, e.mask);
                end
            end
        end
        if (chk_zero) begin
            n_vec++;
            if (avs_readdata !== 32'h0) begin
                n_err++;
                $display("FAIL readdata_reset: got %h expected 0", avs_readdata);
            end
        end
        if (chk_drain) begin
            n_vec++;
            if (sb_q.size() != 0) begin
                n_err++;
                $display("FAIL scoreboard_drain: %0d reads never returned, expected 0", sb_q.size());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: repeated multiplication. Overflow means the mathematical
    // power does not fit in 32 bits; low bits stay exact modulo 2^32.
    function automatic void model(input logic [31:0] bs, input logic [31:0] ex,
                                  output logic [31:0] r, output bit ovf);
        logic [63:0] t;
        r = 32'd1;
        ovf = 1'b0;
        for (longint unsigned i = 0; i < ex; i++) begin
            t = {32'd0, r} * {32'd0, bs};
            if (t[63:32] != 32'd0) ovf = 1'b1;
            r = t[31:0];
        end
    endfunction

    // Number of RUN cycles = number of significant bits in the exponent.
    function automatic int run_cycles(input logic [31:0] ex);
        int n = 0;
        logic [31:0] t = ex;
        while (t != 0) begin
            n++;
            t = t / 2;
        end
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input string nm,
                      input logic [31:0] v, input logic [31:0] m);
        exp_t e;
        e.name = nm;
        e.val  = v;
        e.mask = m;
        sb_q.push_back(e);
        avs_address = a;
        avs_read = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
    endtask

    task automatic run_pow(input logic [31:0] bs, input logic [31:0] ex, input string nm);
        logic [31:0] r;
        bit          ovf;
        int          nrun;
        model(bs, ex, r, ovf);
        nrun = run_cycles(ex);
        wr(3'd0, bs);
        wr(3'd1, ex);
        wr(3'd2, 32'd1);
        for (int i = 1; i <= nrun; i++) rd(3'd3, {nm, "_busy"}, 32'h1, 32'h1);
        rd(3'd3, {nm, "_status"}, {29'd0, ovf, 2'b10}, 32'hFFFF_FFFF);
        rd(3'd4, {nm, "_result"}, r, 32'hFFFF_FFFF);
    endtask

    task automatic pulse_reset;
        idle(1);
        rst_n = 1'b0;
        chk_zero = 1'b1;
        idle(1);
        chk_zero = 1'b0;
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic [31:0] r;
        bit          ovf;
        logic [31:0] bs, ex;

        idle(2);
        pulse_reset();

        // Reset state
        rd(3'd0, "rst_base",   32'h0, 32'hFFFF_FFFF);
        rd(3'd1, "rst_exp",    32'h0, 32'hFFFF_FFFF);
        rd(3'd3, "rst_status", 32'h0, 32'hFFFF_FFFF);
        rd(3'd4, "rst_result", 32'h0, 32'hFFFF_FFFF);

        // Directed operands
        run_pow(32'd3, 32'd5, "p3_5");
        rd(3'd2, "ctrl_reads0", 32'h0, 32'hFFFF_FFFF);
        run_pow(32'd7, 32'd0, "p7_0");
        run_pow(32'd0, 32'd0, "p0_0");
        run_pow(32'd0, 32'd9, "p0_9");
        run_pow(32'd1, 32'd200, "p1_200");
        run_pow(32'd2, 32'd31, "p2_31");
        run_pow(32'd2, 32'd32, "p2_32");
        run_pow(32'd65536, 32'd3, "p65536_3");

        // Unmapped addresses
        wr(3'd5, 32'hDEAD_BEEF);
        rd(3'd5, "addr5", 32'h0, 32'hFFFF_FFFF);
        rd(3'd6, "addr6", 32'h0, 32'hFFFF_FFFF);
        rd(3'd7, "addr7", 32'h0, 32'hFFFF_FFFF);
        rd(3'd0, "base_after_addr5", 32'd65536, 32'hFFFF_FFFF);

        // Start and BASE write while busy: original operands continue
        model(32'd3, 32'd255, r, ovf);
        wr(3'd0, 32'd3);
        wr(3'd1, 32'd255);
        wr(3'd2, 32'd1);
        rd(3'd3, "sb_busy", 32'h1, 32'h1);
        rd(3'd3, "sb_busy", 32'h1, 32'h1);
        wr(3'd2, 32'd1);
        wr(3'd0, 32'd2);
        for (int i = 0; i < 4; i++) rd(3'd3, "sb_busy", 32'h1, 32'h1);
        rd(3'd3, "sb_status", {29'd0, ovf, 2'b10}, 32'hFFFF_FFFF);
        rd(3'd4, "sb_result", r, 32'hFFFF_FFFF);
        rd(3'd0, "sb_base", 32'd2, 32'hFFFF_FFFF);
        rd(3'd1, "sb_exp", 32'd255, 32'hFFFF_FFFF);

        // Reset in the middle of a run
        wr(3'd0, 32'd3);
        wr(3'd1, 32'd255);
        wr(3'd2, 32'd1);
        idle(3);
        rst_n = 1'b0;
        chk_zero = 1'b1;
        idle(1);
        chk_zero = 1'b0;
        rst_n = 1'b1;
        idle(2);
        rd(3'd3, "mr_status", 32'h0, 32'hFFFF_FFFF);
        rd(3'd4, "mr_result", 32'h0, 32'hFFFF_FFFF);
        rd(3'd0, "mr_base",   32'h0, 32'hFFFF_FFFF);
        rd(3'd1, "mr_exp",    32'h0, 32'hFFFF_FFFF);
        run_pow(32'd3, 32'd5, "mr_p3_5");

        // Randomized operands
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: bs = $urandom_range(0, 5);
                1: bs = $urandom_range(0, 300);
                2: bs = $urandom;
                default: bs = 32'd1 << $urandom_range(0, 31);
            endcase
            ex = $urandom_range(0, 260);
            run_pow(bs, ex, $sformatf("rnd%0d", n));
        end

        idle(3);
        chk_drain = 1'b1;
        idle(1);
        chk_drain = 1'b0;
        idle(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
